display_cronometro: RTL and testbench

DISPLAY_CRONOMETRO -- requirements
Module: display_cronometro

---
 rtl/display_cronometro.sv | 184 ++++++++++++++++++
 tb/tb_display_cronometro.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/display_cronometro.sv
// Stopwatch display driver: converts seconds/tenths to four 7-segment digits
// through a serial double-dabble, with leading-zero blanking and a limit flash.
//
// state    | meaning
// CAPTURA  | latch inputs, clear BCD accumulator, load shift count
// CONVERTE | one double-dabble step per cycle (10 cycles)
// ATUALIZA | register digits/segments, pulse atualizado
module display_cronometro #(
  parameter int HALF_BLINK = 12500000,
  parameter int N_BLINK    = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] cont_seg,
  input  logic [3:0] cont_dec,
  input  logic       limite,
  output logic [6:0] hex3,
  output logic [6:0] hex2,
  output logic [6:0] hex1,
  output logic [6:0] hex0,
  output logic       dp1,
  output logic [3:0] dig_cent,
  output logic [3:0] dig_dez,
  output logic [3:0] dig_uni,
  output logic [3:0] dig_dec,
  output logic       atualizado
);

  localparam logic [1:0] CAPTURA  = 2'd0;
  localparam logic [1:0] CONVERTE = 2'd1;
  localparam logic [1:0] ATUALIZA = 2'd2;

  localparam int TW = (HALF_BLINK > 1) ? $clog2(HALF_BLINK) : 1;
  localparam int HW = (N_BLINK > 1) ? $clog2(N_BLINK) : 1;
  localparam logic [TW-1:0] HALF_M1 = TW'(HALF_BLINK - 1);
  localparam logic [HW-1:0] N_M1    = HW'(N_BLINK - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  logic [1:0]  state;
  logic [9:0]  seg_sh;
  logic [3:0]  dec_l;
  logic        invalid_l;
  logic [11:0] bcd;
  logic [11:0] bcd_adj;
  logic [3:0]  sh_cnt;

  logic [6:0]  hex3_r, hex2_r, hex1_r, hex0_r;
  logic        dp_r;

  logic          lim_prev;
  logic          flash_on;
  logic [HW-1:0] half_idx;
  logic [TW-1:0] blink_tmr;
  logic          blank;

  function automatic logic [3:0] dab(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  assign bcd_adj = {dab(bcd[11:8]), dab(bcd[7:4]), dab(bcd[3:0])};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= CAPTURA;
      seg_sh    <= '0;
      dec_l     <= '0;
      invalid_l <= 1'b0;
      bcd       <= '0;
      sh_cnt    <= '0;
    end else begin
      case (state)
        CAPTURA: begin
          seg_sh    <= cont_seg;
          dec_l     <= cont_dec;
          invalid_l <= (cont_seg > 10'd999) || (cont_dec > 4'd9);
          bcd       <= '0;
          sh_cnt    <= 4'd10;
          state     <= CONVERTE;
        end
        CONVERTE: begin
          bcd    <= {bcd_adj[10:0], seg_sh[9]};
          seg_sh <= {seg_sh[8:0], 1'b0};
          sh_cnt <= sh_cnt - 4'd1;
          if (sh_cnt == 4'd1) state <= ATUALIZA;
        end
        ATUALIZA: state <= CAPTURA;
        default:  state <= CAPTURA;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hex3_r     <= SEG_BLANK;
      hex2_r     <= SEG_BLANK;
      hex1_r     <= SEG_BLANK;
      hex0_r     <= SEG_BLANK;
      dp_r       <= 1'b1;
      dig_cent   <= '0;
      dig_dez    <= '0;
      dig_uni    <= '0;
      dig_dec    <= '0;
      atualizado <= 1'b0;
    end else begin
      atualizado <= (state == ATUALIZA);
      if (state == ATUALIZA) begin
        if (invalid_l) begin
          hex3_r   <= SEG_DASH;
          hex2_r   <= SEG_DASH;
          hex1_r   <= SEG_DASH;
          hex0_r   <= SEG_DASH;
          dp_r     <= 1'b1;
          dig_cent <= 4'hF;
          dig_dez  <= 4'hF;
          dig_uni  <= 4'hF;
          dig_dec  <= 4'hF;
        end else begin
          // only leading zeros blank; an inner zero (e.g. 105) stays lit
          hex3_r   <= (bcd[11:8] == 4'd0) ? SEG_BLANK : seg7(bcd[11:8]);
          hex2_r   <= (bcd[11:4] == 8'd0) ? SEG_BLANK : seg7(bcd[7:4]);
          hex1_r   <= seg7(bcd[3:0]);
          hex0_r   <= seg7(dec_l);
          dp_r     <= 1'b0;
          dig_cent <= bcd[11:8];
          dig_dez  <= bcd[7:4];
          dig_uni  <= bcd[3:0];
          dig_dec  <= dec_l;
        end
      end
    end
  end

  // Flash runs independently of the conversion loop; it ends saturated.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lim_prev  <= 1'b0;
      flash_on  <= 1'b0;
      half_idx  <= '0;
      blink_tmr <= '0;
    end else begin
      lim_prev <= limite;
      if (limite && !lim_prev) begin
        flash_on  <= 1'b1;
        half_idx  <= '0;
        blink_tmr <= HALF_M1;
      end else if (flash_on) begin
        if (blink_tmr == '0) begin
          blink_tmr <= HALF_M1;
          if (half_idx == N_M1) flash_on <= 1'b0;
          else                  half_idx <= half_idx + 1'b1;
        end else begin
          blink_tmr <= blink_tmr - 1'b1;
        end
      end
    end
  end

  assign blank = flash_on && !half_idx[0];

  assign hex3 = blank ? SEG_BLANK : hex3_r;
  assign hex2 = blank ? SEG_BLANK : hex2_r;
  assign hex1 = blank ? SEG_BLANK : hex1_r;
  assign hex0 = blank ? SEG_BLANK : hex0_r;
  assign dp1  = blank ? 1'b1 : dp_r;

endmodule

// File: tb/tb_display_cronometro.sv
// Directed bench for display_cronometro with a short blink (HALF_BLINK=4, N_BLINK=4).
module tb_display_cronometro;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] cont_seg;
  logic [3:0] cont_dec;
  logic       limite;
  logic [6:0] hex3, hex2, hex1, hex0;
  logic       dp1;
  logic [3:0] dig_cent, dig_dez, dig_uni, dig_dec;
  logic       atualizado;

  int checks = 0;
  int failures = 0;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] DS = 7'b0111111;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;

  display_cronometro #(.HALF_BLINK(4), .N_BLINK(4)) dut (
    .clk(clk), .reset(reset), .cont_seg(cont_seg), .cont_dec(cont_dec),
    .limite(limite), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
    .dp1(dp1), .dig_cent(dig_cent), .dig_dez(dig_dez), .dig_uni(dig_uni),
    .dig_dec(dig_dec), .atualizado(atualizado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [6:0] h3, input logic [6:0] h2,
                          input logic [6:0] h1, input logic [6:0] h0, input logic dp);
    chk({tag, ".hex3"}, hex3, h3);
    chk({tag, ".hex2"}, hex2, h2);
    chk({tag, ".hex1"}, hex1, h1);
    chk({tag, ".hex0"}, hex0, h0);
    chk({tag, ".dp1"}, dp1, dp);
  endtask

  task automatic chk_dig(input string tag, input logic [3:0] c, input logic [3:0] d,
                         input logic [3:0] u, input logic [3:0] t);
    chk({tag, ".cent"}, dig_cent, c);
    chk({tag, ".dez"}, dig_dez, d);
    chk({tag, ".uni"}, dig_uni, u);
    chk({tag, ".dec"}, dig_dec, t);
  endtask

  // new inputs applied right after an update are captured on the next edge
  task automatic frame(input logic [9:0] s, input logic [3:0] d, input string tag);
    cont_seg = s;
    cont_dec = d;
    tick(11);
    chk({tag, ".atu_early"}, atualizado, 1'b0);
    tick(1);
    chk({tag, ".atu"}, atualizado, 1'b1);
  endtask

  initial begin
    reset = 1'b0;
    cont_seg = 10'd0;
    cont_dec = 4'd0;
    limite = 1'b0;
    tick(3);
    chk_disp("rst", BL, BL, BL, BL, 1'b1);
    chk_dig("rst", 4'd0, 4'd0, 4'd0, 4'd0);
    chk("rst.atu", atualizado, 1'b0);

    reset = 1'b1;
    frame(10'd0, 4'd0, "zero");
    chk_disp("zero", BL, BL, S0, S0, 1'b0);
    chk_dig("zero", 4'd0, 4'd0, 4'd0, 4'd0);
    tick(1);
    chk("period.low", atualizado, 1'b0);
    tick(11);
    chk("period.high", atualizado, 1'b1);

    // change inputs mid-conversion: the in-flight 999/9 must win
    cont_seg = 10'd999;
    cont_dec = 4'd9;
    tick(3);
    cont_seg = 10'd5;
    cont_dec = 4'd1;
    tick(9);
    chk("max.atu", atualizado, 1'b1);
    chk_disp("max", S9, S9, S9, S9, 1'b0);
    chk_dig("max", 4'd9, 4'd9, 4'd9, 4'd9);

    frame(10'd105, 4'd3, "inner0");
    chk_disp("inner0", S1, S0, S5, S3, 1'b0);
    chk_dig("inner0", 4'd1, 4'd0, 4'd5, 4'd3);

    frame(10'd1000, 4'd0, "ovf_seg");
    chk_disp("ovf_seg", DS, DS, DS, DS, 1'b1);
    chk_dig("ovf_seg", 4'hF, 4'hF, 4'hF, 4'hF);

    frame(10'd5, 4'd10, "ovf_dec");
    chk_disp("ovf_dec", DS, DS, DS, DS, 1'b1);
    chk_dig("ovf_dec", 4'hF, 4'hF, 4'hF, 4'hF);

    frame(10'd42, 4'd7, "tens");
    chk_disp("tens", BL, S4, S2, S7, 1'b0);
    chk_dig("tens", 4'd0, 4'd4, 4'd2, 4'd7);

    // flash: blank 1-4, normal 5-8, blank 9-12, normal 13-16, steady after
    limite = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      tick(1);
      if ((c >= 1 && c <= 4) || (c >= 9 && c <= 12))
        chk_disp($sformatf("flash%0d", c), BL, BL, BL, BL, 1'b1);
      else
        chk_disp($sformatf("flash%0d", c), BL, S4, S2, S7, 1'b0);
    end

    // restart during the normal half-period
    limite = 1'b0;
    tick(1);
    limite = 1'b1;
    tick(1);
    chk_disp("rs.c1", BL, BL, BL, BL, 1'b1);
    tick(4);
    chk_disp("rs.c5", BL, S4, S2, S7, 1'b0);
    limite = 1'b0;
    tick(1);
    limite = 1'b1;
    tick(1);
    chk_disp("rs.new1", BL, BL, BL, BL, 1'b1);
    tick(3);
    chk_disp("rs.new4", BL, BL, BL, BL, 1'b1);
    tick(1);
    chk_disp("rs.new5", BL, S4, S2, S7, 1'b0);
    limite = 1'b0;

    begin : sync_frame
      int n;
      n = 0;
      while (atualizado !== 1'b1 && n < 13) begin
        tick(1);
        n++;
      end
      chk("sync.atu", atualizado, 1'b1);
    end

    // reset mid-conversion
    cont_seg = 10'd57;
    cont_dec = 4'd0;
    tick(3);
    reset = 1'b0;
    #1;
    chk_disp("midrst", BL, BL, BL, BL, 1'b1);
    chk_dig("midrst", 4'd0, 4'd0, 4'd0, 4'd0);
    chk("midrst.atu", atualizado, 1'b0);
    tick(2);
    reset = 1'b1;
    tick(11);
    chk("post.atu_early", atualizado, 1'b0);
    chk("post.hex1_early", hex1, BL);
    tick(1);
    chk("post.atu", atualizado, 1'b1);
    chk_disp("post", BL, S5, S7, S0, 1'b0);
    chk_dig("post", 4'd0, 4'd5, 4'd7, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
